// File: rtl/parking_pkg.sv
// Shared types and constants for the car-park gate controller.
// Holds the state enum, the status codes and the default passwords.
package parking_pkg;

  // Status codes presented on `out`.
  localparam logic [2:0] ST_IDLE  = 3'b000;
  localparam logic [2:0] ST_WAIT  = 3'b001;
  localparam logic [2:0] ST_WRONG = 3'b010;
  localparam logic [2:0] ST_RIGHT = 3'b011;
  localparam logic [2:0] ST_STOP  = 3'b100;

  // Default password fields.
  localparam logic [1:0] PASS1_DEF = 2'b01;
  localparam logic [1:0] PASS2_DEF = 2'b10;

  typedef enum logic [2:0] {
    IDLE          = 3'b000,
    WAIT_PASSWORD = 3'b001,
    WRONG_PASS    = 3'b010,
    RIGHT_PASS    = 3'b011,
    STOP          = 3'b100
  } state_e;

endpackage

// File: rtl/parking_system.sv
// Car-park gate controller: Moore FSM with settling wait and password check.
// Ports: clk, reset_n (async, active-high), sensor_entrance, sensor_exit,
//        password_1/2 (2b each), out (3b status code of current state).
module parking_system
  import parking_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 4,
  parameter logic [1:0]  PASS1       = PASS1_DEF,
  parameter logic [1:0]  PASS2       = PASS2_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       sensor_entrance,
  input  logic       sensor_exit,
  input  logic [1:0] password_1,
  input  logic [1:0] password_2,
  output logic [2:0] out
);

  localparam logic [7:0] LAST = 8'(WAIT_CYCLES - 1);

  state_e     state_q;
  state_e     state_d;
  logic [7:0] cnt_q;
  logic [7:0] cnt_d;
  logic       pass_ok;

  assign pass_ok = (password_1 == PASS1) &&
                   (password_2 == PASS2);

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Counter only runs in WAIT_PASSWORD; every other path clears it.
  always_comb begin
    state_d = IDLE;
    cnt_d   = '0;
    case (state_q)
      IDLE: begin
        if (sensor_entrance) state_d = WAIT_PASSWORD;
        else                 state_d = IDLE;
      end
      WAIT_PASSWORD: begin
        if (cnt_q == LAST) begin
          state_d = pass_ok ? RIGHT_PASS : WRONG_PASS;
        end else begin
          state_d = WAIT_PASSWORD;
          cnt_d   = cnt_q + 8'd1;
        end
      end
      WRONG_PASS: begin
        state_d = pass_ok ? RIGHT_PASS : WRONG_PASS;
      end
      RIGHT_PASS: begin
        if (sensor_entrance && sensor_exit) state_d = STOP;
        else if (sensor_exit)               state_d = IDLE;
        else                                state_d = RIGHT_PASS;
      end
      STOP: begin
        state_d = pass_ok ? RIGHT_PASS : STOP;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out = ST_IDLE;
    case (state_q)
      IDLE:          out = ST_IDLE;
      WAIT_PASSWORD: out = ST_WAIT;
      WRONG_PASS:    out = ST_WRONG;
      RIGHT_PASS:    out = ST_RIGHT;
      STOP:          out = ST_STOP;
      default:       out = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_parking_system.sv
// Directed-vector bench for parking_system.
// Drives sensors/passwords and checks `out` against hand-computed codes.
module tb_parking_system;

  logic       clk;
  logic       reset_n;
  logic       sensor_entrance;
  logic       sensor_exit;
  logic [1:0] password_1;
  logic [1:0] password_2;
  logic [2:0] out;

  int n_cmp;
  int n_bad;

  parking_system dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .sensor_entrance (sensor_entrance),
    .sensor_exit     (sensor_exit),
    .password_1      (password_1),
    .password_2      (password_2),
    .out             (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [2:0] got,
                     input logic [2:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Sample 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pw(input logic [1:0] a, input logic [1:0] b);
    password_1 = a;
    password_2 = b;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset_n = 1'b1;
    sensor_entrance = 1'b0;
    sensor_exit = 1'b0;
    pw(2'b00, 2'b00);

    // Reset held with random inputs.
    for (int i = 0; i < 5; i++) begin
      sensor_entrance = 1'($urandom);
      sensor_exit = 1'($urandom);
      pw(2'($urandom), 2'($urandom));
      tick();
      chk($sformatf("rst_hold%0d", i), out, 3'b000);
    end

    // Wrong password path.
    reset_n = 1'b0;
    sensor_exit = 1'b0;
    sensor_entrance = 1'b1;
    pw(2'b01, 2'b01);
    tick();
    chk("wrong_enter", out, 3'b001);
    sensor_entrance = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("wrong_wait%0d", i), out, 3'b001);
    end
    tick();
    chk("wrong_pass", out, 3'b010);
    tick();
    chk("wrong_hold", out, 3'b010);

    // Recovery.
    pw(2'b01, 2'b10);
    tick();
    chk("recover", out, 3'b011);

    // Tailgate.
    sensor_entrance = 1'b1;
    sensor_exit = 1'b1;
    pw(2'b00, 2'b00);
    tick();
    chk("tail_stop", out, 3'b100);
    tick();
    chk("stop_hold", out, 3'b100);
    sensor_exit = 1'b0;
    pw(2'b01, 2'b10);
    tick();
    chk("stop_right", out, 3'b011);
    tick();
    chk("right_hold", out, 3'b011);
    sensor_entrance = 1'b0;
    sensor_exit = 1'b1;
    tick();
    chk("exit_idle", out, 3'b000);
    sensor_exit = 1'b0;
    tick();
    chk("idle_hold", out, 3'b000);

    // Correct on first try.
    sensor_entrance = 1'b1;
    tick();
    chk("ok_enter", out, 3'b001);
    sensor_entrance = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("ok_wait%0d", i), out, 3'b001);
    end
    tick();
    chk("ok_right", out, 3'b011);
    sensor_exit = 1'b1;
    tick();
    chk("ok_exit", out, 3'b000);
    sensor_exit = 1'b0;

    // Correct early, wrong on the sampling cycle.
    sensor_entrance = 1'b1;
    tick();
    chk("late_enter", out, 3'b001);
    sensor_entrance = 1'b0;
    tick();
    tick();
    tick();
    chk("late_wait", out, 3'b001);
    pw(2'b01, 2'b01);
    tick();
    chk("late_wrong", out, 3'b010);
    pw(2'b01, 2'b10);
    tick();
    chk("late_right", out, 3'b011);

    // Async reset in RIGHT_PASS, no edge needed.
    #2;
    reset_n = 1'b1;
    #1;
    chk("async_rst", out, 3'b000);
    tick();
    chk("rst_stay", out, 3'b000);

    // Mid-wait reset clears the counter.
    reset_n = 1'b0;
    sensor_entrance = 1'b1;
    tick();
    chk("mid_enter", out, 3'b001);
    tick();
    chk("mid_wait2", out, 3'b001);
    #2;
    reset_n = 1'b1;
    #1;
    chk("mid_rst", out, 3'b000);
    #1;
    reset_n = 1'b0;
    tick();
    chk("re_enter", out, 3'b001);
    sensor_entrance = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("re_wait%0d", i), out, 3'b001);
    end
    tick();
    chk("re_right", out, 3'b011);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/parking_system.md
Name: parking_system

Overview:
- Car-park gate controller: a Moore FSM that detects an arriving car, waits a fixed settling window, checks a two-field password, and admits the car, blocks it, or holds a following car.
- Sits between the gate sensors/keypad and the gate/indicator driver.
- The 3-bit status code `out` drives the indicator/display logic downstream.

Parameters:
- WAIT_CYCLES, 4, number of clock cycles spent in WAIT_PASSWORD before the password is sampled (legal range 1..255).
- PASS1, 2'b01, expected value of password_1.
- PASS2, 2'b10, expected value of password_2.

Ports:
- clk  input  1  system clock, rising-edge active.
- reset_n  input  1  asynchronous reset, active-high: 1 = reset (name is kept for codebase consistency).
- sensor_entrance  input  1  car present at the entrance.
- sensor_exit  input  1  car present at the exit / has passed the gate.
- password_1  input  2  first password field.
- password_2  input  2  second password field.
- out  output  3  status code of the current state.

Behaviour:
- Inputs are synchronous to clk; no internal synchronisers.
- pass_ok = (password_1 == PASS1) && (password_2 == PASS2).
- Reset (reset_n = 1, asynchronous): state = IDLE, wait counter = 0, out = 3'b000 immediately. Reset asserted mid-operation aborts any state, including a partial wait count.
- Moore machine: out is decoded only from the state register, so an input change affects out one clock edge later.
- Status codes: IDLE = 000, WAIT_PASSWORD = 001, WRONG_PASS = 010, RIGHT_PASS = 011, STOP = 100. Codes 101–111 are never driven.
- Transitions (evaluated at each rising edge):
  - IDLE: sensor_entrance = 1 -> WAIT_PASSWORD; otherwise stay.
  - WAIT_PASSWORD: the 8-bit wait counter is 0 on entry and increments every cycle in this state. When counter == WAIT_CYCLES-1: pass_ok -> RIGHT_PASS, else -> WRONG_PASS, and the counter clears. Otherwise stay. The password is sampled only on that final cycle; sensor inputs are ignored in this state.
  - WRONG_PASS: pass_ok -> RIGHT_PASS; otherwise stay. Sensors are ignored.
  - RIGHT_PASS, checked in priority order:
    - sensor_entrance = 1 and sensor_exit = 1 -> STOP (next car arriving while the gate is open).
    - sensor_exit = 1 only -> IDLE.
    - Otherwise stay.
  - STOP: pass_ok -> RIGHT_PASS; otherwise stay.
- Wait counter:
  - Clears whenever the state is not WAIT_PASSWORD.
  - Does not wrap within legal parameter values.
  - Exactly WAIT_CYCLES clocks are spent in WAIT_PASSWORD.
- Illegal or unreachable state encodings recover to IDLE on the next edge.

Decomposition:
- Shared package parking_pkg holds:
  - the state enum (IDLE, WAIT_PASSWORD, WRONG_PASS, RIGHT_PASS, STOP);
  - the 3-bit status-code constants;
  - default PASS1/PASS2 constants.
- No sub-module: the wait counter stays inline; a separate counter block is not justified.

Test Plan:
- Reset: hold reset_n = 1 for 5 cycles with random inputs -> out = 000 throughout. Assert reset_n while in RIGHT_PASS -> out = 000 with no clock edge needed.
- Wrong password: release reset, sensor_entrance = 1, passwords 01/01 -> out = 001 after 1 edge, stays 001 for 4 cycles, then 010 and holds while passwords remain wrong.
- Recovery: from WRONG_PASS set passwords 01/10 -> out = 011 on the next edge.
- Tailgate: in RIGHT_PASS set sensor_entrance = 1, sensor_exit = 1 -> out = 100. Then sensor_exit = 0 with passwords 01/10 -> 011. Then sensor_exit = 1, sensor_entrance = 0 -> 000.
- Correct first try: sensor_entrance pulse with passwords 01/10 -> 001 for 4 cycles, then 011. A password change that is correct only before the final wait cycle and wrong on it -> 010.
- Mid-wait reset: assert reset on the 2nd WAIT cycle, release, re-enter -> a full 4-cycle wait is required again (counter was cleared).
